// File: rtl/menu_select_ctl.sv
// Interactive VGA menu overlay: hit-tests the mouse against N item boxes, draws hover/selection, commits clicks.
// Optional keyboard cursor/enter inputs are compiled in when MENU_KEYBOARD_EN is defined.
module menu_select_ctl #(
  parameter int          N_ITEMS     = 4,
  parameter int          ITEM_X      = 384,
  parameter int          ITEM_W      = 256,
  parameter int          ITEM_Y0     = 200,
  parameter int          ITEM_H      = 32,
  parameter int          ITEM_PITCH  = 192,
  parameter int          BORDER      = 2,
  parameter logic [11:0] HOVER_RGB   = 12'hFF0,
  parameter logic [11:0] SEL_RGB     = 12'h0F0,
  parameter logic [7:0]  TOGGLE_MASK = 8'b0000_0010,
  localparam int         IW          = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        vcount_in,
  input  logic [10:0]        hcount_in,
  input  logic               vsync_in,
  input  logic               hsync_in,
  input  logic               vblnk_in,
  input  logic               hblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic [11:0]        xpos,
  input  logic [11:0]        ypos,
  input  logic               mouse_left,
`ifdef MENU_KEYBOARD_EN
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_enter,
`endif
  output logic [10:0]        vcount_out,
  output logic [10:0]        hcount_out,
  output logic               vsync_out,
  output logic               hsync_out,
  output logic               vblnk_out,
  output logic               hblnk_out,
  output logic [11:0]        rgb_out,
  output logic               hover_valid,
  output logic [IW-1:0]      hover_idx,
  output logic [IW-1:0]      choice_idx,
  output logic               choice_strobe,
  output logic [N_ITEMS-1:0] option_bits
);

  localparam logic [11:0] X_LO  = 12'(ITEM_X);
  localparam logic [11:0] X_HI  = 12'(ITEM_X + ITEM_W);
  localparam logic [11:0] XB_LO = 12'(ITEM_X + BORDER);
  localparam logic [11:0] XB_HI = 12'(ITEM_X + ITEM_W - BORDER);

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
    logic          border;
  } hit_t;

  typedef enum logic [1:0] {LOCK, IDLE, PRESS, WAIT_REL} click_state_t;

  // At most one box can match because the pitch is never smaller than the box height.
  function automatic hit_t hit_test(input logic [11:0] x, input logic [11:0] y);
    hit_t        r;
    logic [11:0] top, bot, top_b, bot_b;
    r = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      top   = 12'(ITEM_Y0 + i * ITEM_PITCH);
      bot   = 12'(ITEM_Y0 + i * ITEM_PITCH + ITEM_H);
      top_b = 12'(ITEM_Y0 + i * ITEM_PITCH + BORDER);
      bot_b = 12'(ITEM_Y0 + i * ITEM_PITCH + ITEM_H - BORDER);
      if (x >= X_LO && x < X_HI && y >= top && y < bot) begin
        r.hit    = 1'b1;
        r.idx    = IW'(i);
        r.border = (x < XB_LO) || (x >= XB_HI) || (y < top_b) || (y >= bot_b);
      end
    end
    return r;
  endfunction

  hit_t pix_hit, mouse_hit;
  always_comb begin
    pix_hit   = hit_test({1'b0, hcount_in}, {1'b0, vcount_in});
    mouse_hit = hit_test(xpos, ypos);
  end

  // ---------------- video pipeline ----------------
  logic          s1_hit_q, s1_border_q;
  logic [IW-1:0] s1_idx_q;
  logic [11:0]   s1_rgb_q, rgb_q, rgb_d;
  logic [10:0]   s1_vc_q, s1_hc_q, vc_q, hc_q;
  logic [3:0]    s1_strb_q, strb_q;   // {vsync, hsync, vblnk, hblnk}

  logic          hover_valid_q, committed_q;
  logic [IW-1:0] hover_idx_q, choice_idx_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rgb_d = s1_rgb_q;
    if (s1_hit_q) begin
      if (hover_valid_q && hover_idx_q == s1_idx_q && s1_border_q)
        rgb_d = HOVER_RGB;
      else if (committed_q && choice_idx_q == s1_idx_q && s1_rgb_q == 12'h000)
        rgb_d = SEL_RGB;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_hit_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_idx_q    <= '0;
      s1_rgb_q    <= '0;
      s1_vc_q     <= '0;
      s1_hc_q     <= '0;
      s1_strb_q   <= '0;
      rgb_q       <= '0;
      vc_q        <= '0;
      hc_q        <= '0;
      strb_q      <= '0;
    end else begin
      s1_hit_q    <= pix_hit.hit & ~(hblnk_in | vblnk_in);
      s1_border_q <= pix_hit.border;
      s1_idx_q    <= pix_hit.idx;
      s1_rgb_q    <= rgb_in;
      s1_vc_q     <= vcount_in;
      s1_hc_q     <= hcount_in;
      s1_strb_q   <= {vsync_in, hsync_in, vblnk_in, hblnk_in};
      rgb_q       <= rgb_d;
      vc_q        <= s1_vc_q;
      hc_q        <= s1_hc_q;
      strb_q      <= s1_strb_q;
    end
  end

  // ---------------- hover register ----------------
  logic          vblnk_prev_q, vblnk_rise;
  logic          hover_valid_d;
  logic [IW-1:0] hover_idx_d;
`ifdef MENU_KEYBOARD_EN
  logic          kbd_mode_q, kbd_mode_d, mouse_moved;
  logic [11:0]   kx_q, ky_q, kx_d, ky_d;
`endif

  always_comb begin
    vblnk_rise    = vblnk_in & ~vblnk_prev_q;
    hover_valid_d = hover_valid_q;
    hover_idx_d   = hover_idx_q;
`ifdef MENU_KEYBOARD_EN
    kbd_mode_d  = kbd_mode_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    mouse_moved = (xpos != kx_q) || (ypos != ky_q);
    if (kbd_mode_q && mouse_moved) kbd_mode_d = 1'b0;
    if (key_up || key_down) begin
      if (key_up)
        hover_idx_d = (hover_idx_q == '0) ? IW'(N_ITEMS - 1) : hover_idx_q - 1'b1;
      else
        hover_idx_d = (hover_idx_q == IW'(N_ITEMS - 1)) ? '0 : hover_idx_q + 1'b1;
      hover_valid_d = 1'b1;
      kbd_mode_d    = 1'b1;
      kx_d          = xpos;
      ky_d          = ypos;
    end else if (vblnk_rise && (!kbd_mode_q || mouse_moved)) begin
      hover_valid_d = mouse_hit.hit;
      hover_idx_d   = mouse_hit.idx;
    end
`else
    if (vblnk_rise) begin
      hover_valid_d = mouse_hit.hit;
      hover_idx_d   = mouse_hit.idx;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q  <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_idx_q   <= '0;
`ifdef MENU_KEYBOARD_EN
      kbd_mode_q    <= 1'b0;
      kx_q          <= '0;
      ky_q          <= '0;
`endif
    end else begin
      vblnk_prev_q  <= vblnk_in;
      hover_valid_q <= hover_valid_d;
      hover_idx_q   <= hover_idx_d;
`ifdef MENU_KEYBOARD_EN
      kbd_mode_q    <= kbd_mode_d;
      kx_q          <= kx_d;
      ky_q          <= ky_d;
`endif
    end
  end

  // ---------------- click FSM ----------------
  // Each state is only entered with the button at a known level, so levels double as edges here.
  click_state_t  state_q, state_d;
  logic [IW-1:0] press_idx_q, press_idx_d, commit_idx;
  logic          commit_req, commit_choice, commit_toggle;
  logic          choice_strobe_q;
  logic [N_ITEMS-1:0] option_bits_q;

  always_comb begin
    state_d     = state_q;
    press_idx_d = press_idx_q;
    commit_req  = 1'b0;
    commit_idx  = press_idx_q;
    case (state_q)
      LOCK:     if (!mouse_left) state_d = IDLE;
      IDLE: begin
        if (mouse_left) begin
          if (mouse_hit.hit) begin
            press_idx_d = mouse_hit.idx;
            state_d     = PRESS;
          end else begin
            state_d = WAIT_REL;
          end
        end
`ifdef MENU_KEYBOARD_EN
        else if (key_enter && hover_valid_q) begin
          commit_req = 1'b1;
          commit_idx = hover_idx_q;
        end
`endif
      end
      PRESS: begin
        if (!mouse_left) begin
          state_d    = IDLE;
          commit_req = mouse_hit.hit && (mouse_hit.idx == press_idx_q);
        end
      end
      WAIT_REL: if (!mouse_left) state_d = IDLE;
      default:  state_d = LOCK;
    endcase
    commit_choice = commit_req & ~TOGGLE_MASK[commit_idx];
    commit_toggle = commit_req &  TOGGLE_MASK[commit_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= LOCK;
      press_idx_q     <= '0;
      choice_idx_q    <= '0;
      choice_strobe_q <= 1'b0;
      committed_q     <= 1'b0;
      option_bits_q   <= '0;
    end else begin
      state_q         <= state_d;
      press_idx_q     <= press_idx_d;
      choice_strobe_q <= commit_choice;
      if (commit_choice) begin
        choice_idx_q <= commit_idx;
        committed_q  <= 1'b1;
      end
      if (commit_toggle) option_bits_q[commit_idx] <= ~option_bits_q[commit_idx];
    end
  end

  assign vcount_out    = vc_q;
  assign hcount_out    = hc_q;
  assign {vsync_out, hsync_out, vblnk_out, hblnk_out} = strb_q;
  assign rgb_out       = rgb_q;
  assign hover_valid   = hover_valid_q;
  assign hover_idx     = hover_idx_q;
  assign choice_idx    = choice_idx_q;
  assign choice_strobe = choice_strobe_q;
  assign option_bits   = option_bits_q;

endmodule

// File: tb/tb_menu_select_ctl.sv
// Self-checking bench for menu_select_ctl: fixed vectors, directed click sequences and randomized
// mouse/pixel/click traffic compared against a geometric reference model.
module tb_menu_select_ctl;

  localparam int N = 4;
  localparam logic [11:0] HOVER = 12'hFF0;
  localparam logic [11:0] SEL   = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        mouse_left;
`ifdef MENU_KEYBOARD_EN
  logic        key_up, key_down, key_enter;
`endif
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
  logic        hover_valid;
  logic [1:0]  hover_idx, choice_idx;
  logic        choice_strobe;
  logic [3:0]  option_bits;

  menu_select_ctl dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
`ifdef MENU_KEYBOARD_EN
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
`endif
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .hover_valid(hover_valid), .hover_idx(hover_idx),
    .choice_idx(choice_idx), .choice_strobe(choice_strobe), .option_bits(option_bits)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit       m_hover_valid;
  int       m_hover_idx;
  int       m_choice;
  bit       m_committed;
  bit [3:0] m_opts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_hover_valid = 0; m_hover_idx = 0; m_choice = 0; m_committed = 0; m_opts = '0;
  endtask

  // Item under (x,y), or -1: box k spans x in [384,640), y in [200+192k, 232+192k).
  function automatic int model_hit(int x, int y);
    int dy;
    if (x < 384 || x >= 640 || y < 200) return -1;
    dy = y - 200;
    if (dy / 192 >= N || dy % 192 >= 32) return -1;
    return dy / 192;
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, logic [11:0] rgb, bit blank);
    int k, rx, ry;
    bit border;
    k = model_hit(x, y);
    if (blank || k < 0) return rgb;
    rx = x - 384;
    ry = (y - 200) % 192;
    border = (rx < 2) || (rx >= 254) || (ry < 2) || (ry >= 30);
    if (m_hover_valid && m_hover_idx == k && border) return HOVER;
    if (m_committed && m_choice == k && rgb == 12'h000) return SEL;
    return rgb;
  endfunction

  task automatic drive_pixel(input int x, input int y, input logic [11:0] rgb, input bit hb, input bit vb);
    hcount_in = 11'(x); vcount_in = 11'(y); rgb_in = rgb;
    hblnk_in = hb; vblnk_in = vb;
    hsync_in = x[0]; vsync_in = y[0];
    step();
    step();
  endtask

  task automatic frame();
    vblnk_in = 1'b0; step();
    vblnk_in = 1'b1; step();
    vblnk_in = 1'b0; step();
    m_hover_valid = model_hit(int'(xpos), int'(ypos)) >= 0;
    if (m_hover_valid) m_hover_idx = model_hit(int'(xpos), int'(ypos));
  endtask

  // Press at (px,py), drag to (rx,ry), release; checks the commit cycle and the cycle after.
  task automatic click(input int px, input int py, input int rx, input int ry);
    int a, b;
    bit exp_strobe;
    xpos = 12'(px); ypos = 12'(py); step();
    mouse_left = 1'b1; step(); step();
    xpos = 12'(rx); ypos = 12'(ry); step();
    mouse_left = 1'b0; step();
    a = model_hit(px, py);
    b = model_hit(rx, ry);
    exp_strobe = 0;
    if (a >= 0 && a == b) begin
      if (a == 1) m_opts[a] = ~m_opts[a];
      else begin
        exp_strobe = 1; m_choice = a; m_committed = 1;
      end
    end
    check("click_strobe", choice_strobe, exp_strobe);
    check("click_choice_idx", choice_idx, m_choice);
    check("click_option_bits", option_bits, m_opts);
    step();
    check("strobe_one_cycle", choice_strobe, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hover_valid"}, hover_valid, 0);
    check({tag, "_hover_idx"}, hover_idx, 0);
    check({tag, "_choice_idx"}, choice_idx, 0);
    check({tag, "_strobe"}, choice_strobe, 0);
    check({tag, "_option_bits"}, option_bits, 0);
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    bit          hb;
    bit          vb;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int px, py, k, n_strobe;
    logic [11:0] r, exp_rgb;
    bit hb;

    // Hover on item 0, nothing committed yet.
    vecs[0]  = '{384, 200, 12'h123, 0, 0, 12'hFF0};
    vecs[1]  = '{500, 215, 12'h000, 0, 0, 12'h000};
    vecs[2]  = '{500, 215, 12'hABC, 0, 0, 12'hABC};
    vecs[3]  = '{639, 231, 12'h000, 0, 0, 12'hFF0};
    vecs[4]  = '{640, 215, 12'h111, 0, 0, 12'h111};
    vecs[5]  = '{383, 215, 12'h222, 0, 0, 12'h222};
    vecs[6]  = '{500, 232, 12'h333, 0, 0, 12'h333};
    vecs[7]  = '{385, 201, 12'h044, 0, 0, 12'hFF0};
    vecs[8]  = '{386, 202, 12'h055, 0, 0, 12'h055};
    vecs[9]  = '{500, 392, 12'h066, 0, 0, 12'h066};
    vecs[10] = '{384, 200, 12'h777, 1, 0, 12'h777};
    vecs[11] = '{384, 200, 12'h788, 0, 1, 12'h788};

    rst = 1'b1; mouse_left = 1'b0;
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    vsync_in = 0; hsync_in = 0; vblnk_in = 0; hblnk_in = 0;
    xpos = 12'd0; ypos = 12'd0;
`ifdef MENU_KEYBOARD_EN
    key_up = 0; key_down = 0; key_enter = 0;
`endif
    model_reset();
    repeat (3) step();
    check("rst_rgb_out", rgb_out, 0);
    check("rst_timing", {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}, 0);
    check_reset_outputs("rst");
    rst = 1'b0;
    step();

    // Hover latch and fixed pixel vectors
    xpos = 12'd400; ypos = 12'd210;
    frame();
    check("hover_valid_item0", hover_valid, 1);
    check("hover_idx_item0", hover_idx, 0);
    foreach (vecs[i]) begin
      drive_pixel(vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].hb, vecs[i].vb);
      check($sformatf("vec%0d_rgb", i), rgb_out, vecs[i].exp);
      check($sformatf("vec%0d_count", i), {vcount_out, hcount_out}, {11'(vecs[i].y), 11'(vecs[i].x)});
      check($sformatf("vec%0d_strobes", i), {vsync_out, hsync_out, vblnk_out, hblnk_out},
            {vecs[i].y[0], vecs[i].x[0], vecs[i].vb, vecs[i].hb});
    end
    vblnk_in = 1'b0;

    // Randomized frames, clicks and pixels
    for (int it = 0; it < 120; it++) begin
      k  = $urandom_range(0, N - 1);
      xpos = 12'($urandom_range(370, 660));
      ypos = 12'(200 + k * 192 + $urandom_range(0, 42) - 5);
      frame();
      check("rand_hover_valid", hover_valid, m_hover_valid);
      if (m_hover_valid) check("rand_hover_idx", hover_idx, m_hover_idx);
      if ($urandom_range(0, 1) == 1) begin
        k  = $urandom_range(0, N - 1);
        px = $urandom_range(375, 650);
        py = 200 + k * 192 + $urandom_range(0, 36) - 2;
        if ($urandom_range(0, 3) == 0) click(px, py, $urandom_range(375, 650), $urandom_range(190, 800));
        else click(px, py, px, py);
      end
      for (int j = 0; j < 3; j++) begin
        k  = $urandom_range(0, N - 1);
        px = $urandom_range(378, 646);
        py = 200 + k * 192 + $urandom_range(0, 38) - 3;
        r  = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
        hb = ($urandom_range(0, 7) == 0);
        exp_rgb = model_rgb(px, py, r, hb);
        drive_pixel(px, py, r, hb, 0);
        check("rand_rgb", rgb_out, exp_rgb);
      end
    end

    // Button held through reset must be released once before any commit.
    rst = 1'b1; mouse_left = 1'b1; xpos = 12'd400; ypos = 12'd210;
    repeat (2) step();
    model_reset();
    check_reset_outputs("lock_rst");
    rst = 1'b0;
    n_strobe = 0;
    repeat (3) begin step(); n_strobe += int'(choice_strobe); end
    mouse_left = 1'b0;
    repeat (3) begin step(); n_strobe += int'(choice_strobe); end
    check("lock_no_strobe", n_strobe, 0);
    click(400, 210, 400, 210);

    // Drag off the pressed item cancels.
    click(400, 590, 400, 700);
    check("drag_choice_kept", choice_idx, 0);

    // Item 1 is a toggle: flips option bit, never strobes.
    click(400, 397, 400, 397);
    check("toggle_on", option_bits, 4'b0010);
    click(400, 397, 400, 397);
    check("toggle_off", option_bits, 4'b0000);
    click(400, 397, 400, 397);
    xpos = 12'd400; ypos = 12'd210;
    frame();

    // Reset while a press is pending.
    mouse_left = 1'b1; step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    model_reset();
    check_reset_outputs("press_rst");
    n_strobe = 0;
    repeat (3) begin step(); n_strobe += int'(choice_strobe); end
    mouse_left = 1'b0;
    repeat (3) begin step(); n_strobe += int'(choice_strobe); end
    check("press_rst_no_strobe", n_strobe, 0);
    drive_pixel(500, 215, 12'h000, 0, 0);
    check("press_rst_sel_cleared", rgb_out, 12'h000);

`ifdef MENU_KEYBOARD_EN
    xpos = 12'd400; ypos = 12'd210;
    frame();
    key_up = 1'b1; step(); key_up = 1'b0;
    check("kbd_up_idx", hover_idx, 3);
    check("kbd_up_valid", hover_valid, 1);
    key_enter = 1'b1; step(); key_enter = 1'b0;
    check("kbd_enter_strobe", choice_strobe, 1);
    check("kbd_enter_choice", choice_idx, 3);
    step();
    check("kbd_strobe_one_cycle", choice_strobe, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/menu_select_ctl.md
# menu_select_ctl

Parametrised, interactive successor to the fixed four-row menu: an in-line VGA pipeline stage that overlays N selectable menu items on upstream pixel data. It hit-tests the mouse against the item boxes and draws a hover border and a selected-item fill. A press/release state machine commits a choice, or flips a per-item option bit. It sits after the text-rendering stages and before the final sync/RGB output register.

## Interface
Parameters:
- N_ITEMS, 4, number of item boxes (1..8)
- ITEM_X, 384, left edge of every box (pixels)
- ITEM_W, 256, box width
- ITEM_Y0, 200, top edge of item 0
- ITEM_H, 32, box height
- ITEM_PITCH, 192, vertical distance between item tops (≥ ITEM_H)
- BORDER, 2, hover border thickness (pixels)
- HOVER_RGB, 12'hFF0, hover border colour
- SEL_RGB, 12'h0F0, fill colour of last committed item (drawn under text: only where rgb_in == 12'h000)
- TOGGLE_MASK, 8'b0000_0010, bit i set → item i is an option toggle, not a choice

Ports (IW = $clog2(N_ITEMS), min 1):
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vcount_in, hcount_in  in  11  timing counters
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1  timing strobes
- rgb_in  in  12  upstream pixel
- xpos, ypos  in  12  mouse position
- mouse_left  in  1  left button level, synchronous to clk
- vcount_out, hcount_out  out  11  delayed counters
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1  delayed strobes
- rgb_out  out  12  composited pixel
- hover_valid  out  1  mouse is over an item
- hover_idx  out  IW  hovered item
- choice_idx  out  IW  last committed choice item
- choice_strobe  out  1  one-cycle pulse on commit of a choice item
- option_bits  out  N_ITEMS  toggle states (bits outside TOGGLE_MASK stay 0)

## Operation
- Hit test: item i is hit when ITEM_X ≤ x < ITEM_X+ITEM_W and ITEM_Y0+i·ITEM_PITCH ≤ y < that+ITEM_H. Comparisons are 12-bit unsigned, with counters zero-extended. At most one item is hit because ITEM_PITCH ≥ ITEM_H.
- Hover register (hover_valid/hover_idx): updated from the xpos/ypos hit test once per frame, on the rising edge of vblnk_in. The overlay therefore never tears mid-frame.
- Rendering, per pixel inside item i:
  - Hovered and inside the BORDER-wide frame → HOVER_RGB.
  - Else if i == choice_idx, rgb_in == 0 and a choice has been committed since reset → SEL_RGB.
  - Else rgb_in.
  - Outside all boxes or during blanking (hblnk|vblnk) → rgb_in.
- Click FSM:
  - LOCK: entered on reset; waits for mouse_left == 0, then goes to IDLE. This rejects a button held through reset.
  - IDLE: on mouse_left rising with an item hit (live xpos/ypos, not the frame-latched hover), latch that index → PRESS. Press over no item → WAIT_REL.
  - PRESS: on mouse_left falling:
    - Same item still hit → commit. Choice item: choice_idx ← index, choice_strobe = 1 for one cycle. Toggle item: option_bits[index] flips, no strobe.
    - Otherwise cancel.
    - Either way → IDLE.
  - WAIT_REL: on mouse_left == 0 → IDLE.
- Reset values:
  - All timing outputs 0; rgb_out 12'h000.
  - hover_valid 0, hover_idx 0, choice_idx 0, choice_strobe 0, option_bits 0.
  - "committed" flag 0; FSM in LOCK.

## Timing
- Video latency: 2 clk cycles for every timing output and rgb_out.
  - Stage 1: registered hit flags, item index, border flag.
  - Stage 2: registered colour mux.
- Commit: choice_strobe and the choice_idx/option_bits update appear on the cycle after the clk edge that samples mouse_left == 0.
- SEL_RGB moves to the new choice at the first stage-2 pixel after the choice_idx update. It is not frame-aligned.
- Press and release both seen within one frame: legal; the frame-latched hover is irrelevant to commit.
- rst asserted in any state wins over every other event: outputs return to reset values on the next edge.

## Configuration
- MENU_KEYBOARD_EN defined:
  - Adds inputs key_up, key_down, key_enter (1-bit, one-cycle pulses).
  - key_up/key_down move the hover cursor immediately, wrapping (0 ↔ N_ITEMS-1), and set hover_valid = 1. The cursor then stays keyboard-driven until xpos or ypos changes.
  - key_enter in IDLE commits the hovered item exactly like a mouse release.
  - key_enter is ignored in LOCK/PRESS/WAIT_REL.
- MENU_KEYBOARD_EN undefined: the ports do not exist; mouse-only behaviour as above.

## Test plan
- Reset with mouse_left = 1, then press/release over item 0 → no strobe until one full release; the next press/release over item 0 gives choice_strobe = 1 for one cycle with choice_idx = 0.
- Mouse at (400, 210), frame boundary → hover_idx = 0, hover_valid = 1. Pixel (384, 200) → rgb_out = 12'hFF0 two cycles after input. Pixel (500, 215) with rgb_in = 0 and no commit yet → 12'h000.
- Press on item 2 (y = 590), drag to y = 700, release → no strobe, choice_idx unchanged.
- Two click cycles on item 1 (toggle) → option_bits = 4'b0010, then 4'b0000; choice_strobe never asserted.
- rst pulse while in PRESS → all outputs reset; a release 3 cycles later produces no strobe.
- With MENU_KEYBOARD_EN: cursor at 0, key_up → hover_idx = 3. key_enter → choice_idx = 3 with a one-cycle strobe.
